// File: rtl/rice_pkg.sv
// Shared types and helpers for the Rice stream sequencer: FSM state encoding,
// packer widths and the signed-to-unsigned zigzag map.
package rice_pkg;

    localparam int RICE_PARAM_W = 4;
    localparam int PACK_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PARAM,
        CODE,
        FLUSH,
        DONE
    } state_t;

    // Interleaves signed values onto unsigned: 0,-1,1,-2,... -> 0,1,2,3,...
    function automatic logic [PACK_W-1:0] zigzag(input logic [PACK_W-1:0] r);
        return (r << 1) ^ {PACK_W{r[PACK_W-1]}};
    endfunction

endpackage

// File: rtl/rice_code_calc.sv
// Combinational Rice code split for one residual: zigzag map, unary/binary split
// and total code length, with a flag when the length no longer fits in PACK_W bits.
module rice_code_calc
    import rice_pkg::*;
(
    input  logic [PACK_W-1:0]       residual,
    input  logic [RICE_PARAM_W-1:0] k,
    output logic [PACK_W-1:0]       upper,
    output logic [PACK_W-1:0]       lower,
    output logic [PACK_W-1:0]       total,
    output logic                    overflow
);

    logic [PACK_W-1:0] mapped;
    logic [PACK_W-1:0] low_mask;
    logic [PACK_W:0]   total_wide;

    always_comb begin
        mapped     = zigzag(residual);
        low_mask   = (PACK_W'(1) << k) - PACK_W'(1);
        upper      = mapped >> k;
        // Leading 1 is the unary terminator, packed together with the k low bits
        lower      = (PACK_W'(1) << k) | (mapped & low_mask);
        total_wide = {1'b0, upper} + (PACK_W+1)'(k) + (PACK_W+1)'(1);
        total      = total_wide[PACK_W-1:0];
        overflow   = total_wide[PACK_W];
    end

endmodule

// File: rtl/rice_stream_sequencer.sv
// Drives the Rice packer for one FLAC residual block: param changes per partition,
// one code per residual, then a flush. Optional bit counter under RICE_BITCOUNT_EN.
module rice_stream_sequencer
    import rice_pkg::*;
#(
    parameter int SAMPLE_W       = 16,
    parameter int PART_SIZE_LOG2 = 8
) (
    input  logic                    iClock,
    input  logic                    iReset_n,
    input  logic                    iFrameStart,
    input  logic [15:0]             iBlockSize,
    input  logic                    iParamValid,
    input  logic [RICE_PARAM_W-1:0] iRiceParam,
    output logic                    oParamReady,
    input  logic                    iValid,
    input  logic [SAMPLE_W-1:0]     iResidual,
    output logic                    oReady,
    output logic                    oEnable,
    output logic                    oChangeParam,
    output logic                    oFlush,
    output logic [PACK_W-1:0]       oTotal,
    output logic [PACK_W-1:0]       oUpper,
    output logic [PACK_W-1:0]       oLower,
    output logic [RICE_PARAM_W-1:0] oRiceParamOut,
    output logic                    oDone,
`ifdef RICE_BITCOUNT_EN
    output logic [31:0]             oBitCount,
`endif
    output logic                    oOverflow
);

    state_t state_reg, state_next;

    logic [15:0]               block_size_reg;
    logic [15:0]               sample_cnt_reg;
    logic [PART_SIZE_LOG2-1:0] part_cnt_reg;
    logic [RICE_PARAM_W-1:0]   k_reg;

    logic              enable_reg, change_reg, flush_reg, done_reg, overflow_reg;
    logic [PACK_W-1:0] total_reg, upper_reg, lower_reg;

    logic enable_next, change_next, flush_next, done_next, issue_next;

    logic start_ok, param_ok, code_fire, last_in_block, last_in_part;

    logic [PACK_W-1:0] calc_upper, calc_lower, calc_total;
    logic              calc_overflow;

    rice_code_calc u_calc (
        .residual (iResidual),
        .k        (k_reg),
        .upper    (calc_upper),
        .lower    (calc_lower),
        .total    (calc_total),
        .overflow (calc_overflow)
    );

    assign start_ok      = (state_reg == IDLE) && iFrameStart;
    assign param_ok      = (state_reg == WAIT_PARAM) && iParamValid;
    assign code_fire     = (state_reg == CODE) && iValid;
    assign last_in_block = (sample_cnt_reg == block_size_reg - 16'd1);
    assign last_in_part  = &part_cnt_reg;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (iFrameStart) begin
                    state_next = (iBlockSize == 16'd0) ? FLUSH : WAIT_PARAM;
                end
            end
            WAIT_PARAM: begin
                if (iParamValid) begin
                    state_next = CODE;
                end
            end
            CODE: begin
                // Block end wins so a short final partition never asks for a new k
                if (iValid) begin
                    if (last_in_block) begin
                        state_next = FLUSH;
                    end else if (last_in_part) begin
                        state_next = WAIT_PARAM;
                    end
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        change_next = param_ok;
        issue_next  = code_fire && !calc_overflow;
        flush_next  = (state_reg == FLUSH);
        done_next   = (state_reg == DONE);
        enable_next = change_next || issue_next || flush_next;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            block_size_reg <= '0;
            sample_cnt_reg <= '0;
            part_cnt_reg   <= '0;
            k_reg          <= '0;
        end else begin
            if (start_ok) begin
                block_size_reg <= iBlockSize;
                sample_cnt_reg <= '0;
                part_cnt_reg   <= '0;
            end
            if (param_ok) begin
                k_reg <= iRiceParam;
            end
            if (code_fire) begin
                sample_cnt_reg <= sample_cnt_reg + 16'd1;
                part_cnt_reg   <= part_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            enable_reg   <= 1'b0;
            change_reg   <= 1'b0;
            flush_reg    <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            total_reg    <= '0;
            upper_reg    <= '0;
            lower_reg    <= '0;
        end else begin
            enable_reg <= enable_next;
            change_reg <= change_next;
            flush_reg  <= flush_next;
            done_reg   <= done_next;
            if (issue_next) begin
                total_reg <= calc_total;
                upper_reg <= calc_upper;
                lower_reg <= calc_lower;
            end
            if (start_ok) begin
                overflow_reg <= 1'b0;
            end else if (code_fire && calc_overflow) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef RICE_BITCOUNT_EN
    logic [31:0] bit_count_reg;

    // Each param change costs a 4-bit k field in the stream
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            bit_count_reg <= '0;
        end else if (start_ok) begin
            bit_count_reg <= '0;
        end else if (change_next) begin
            bit_count_reg <= bit_count_reg + 32'd4;
        end else if (issue_next) begin
            bit_count_reg <= bit_count_reg + {16'd0, calc_total};
        end
    end

    assign oBitCount = bit_count_reg;
`endif

    assign oParamReady   = (state_reg == WAIT_PARAM);
    assign oReady        = (state_reg == CODE);
    assign oEnable       = enable_reg;
    assign oChangeParam  = change_reg;
    assign oFlush        = flush_reg;
    assign oDone         = done_reg;
    assign oOverflow     = overflow_reg;
    assign oTotal        = total_reg;
    assign oUpper        = upper_reg;
    assign oLower        = lower_reg;
    assign oRiceParamOut = k_reg;

endmodule
